// File: rtl/ntt_stage_controller.sv
// Purpose: sequences NTT butterfly stages or one pointwise-multiply pass over the coefficient rows.
// Latency: first read the cycle after start; stage period GROUPS+1+BF_LATENCY; done one cycle after last write.
// Backpressure: none; start is honoured only in IDLE, and a stage never issues before the previous stage's writes finish.
module ntt_stage_controller #(
    parameter int NUM_STAGES = 7,
    parameter int GROUPS     = 8,
    parameter int BF_LATENCY = 4,
    parameter int LUT_SIZE   = 1360
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic                            op,
    output logic                            busy,
    output logic                            done,
    output logic                            array_mode,
    output logic [$clog2(LUT_SIZE):0]       w_idx,
    output logic                            rd_en,
    output logic [$clog2(GROUPS)-1:0]       rd_addr,
    output logic                            rd_bank,
    output logic                            wr_en,
    output logic [$clog2(GROUPS)-1:0]       wr_addr,
    output logic                            wr_bank,
    output logic [$clog2(NUM_STAGES):0]     stage
);

    localparam int AW = $clog2(GROUPS);
    localparam int SW = $clog2(NUM_STAGES) + 1;
    localparam int WW = $clog2(LUT_SIZE) + 1;
    // one cycle of memory read latency plus the butterfly pipeline
    localparam int DL = 1 + BF_LATENCY;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [AW-1:0]   grp_q;
    logic [SW-1:0]   stage_q;
    logic            op_q;
    logic [DL-1:0]   dl_vld;
    logic [AW-1:0]   dl_addr [DL];
    logic            last_grp;
    logic            last_wr;
    logic            last_stage;

    assign last_grp   = (grp_q == AW'(GROUPS - 1));
    assign last_wr    = dl_vld[DL-1] && (dl_addr[DL-1] == AW'(GROUPS - 1));
    // multiply mode is a single pass, so stage 0 is also the last one
    assign last_stage = op_q || (stage_q == SW'(NUM_STAGES - 1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: issue a stage, wait for its last write, then next stage or finish
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_ISSUE;
            S_ISSUE: if (last_grp) state_d = S_DRAIN;
            S_DRAIN: if (last_wr) state_d = last_stage ? S_DONE : S_ISSUE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Row and stage counters plus the command latch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grp_q   <= '0;
            stage_q <= '0;
            op_q    <= 1'b0;
        end else begin
            if (state_q == S_IDLE && start) begin
                op_q    <= op;
                stage_q <= '0;
                grp_q   <= '0;
            end
            if (state_q == S_ISSUE) begin
                grp_q <= last_grp ? '0 : grp_q + AW'(1);
            end
            if (state_q == S_DRAIN && last_wr) begin
                stage_q <= last_stage ? '0 : stage_q + SW'(1);
            end
        end
    end

    // Read-to-write delay line so each write targets the row its read produced
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dl_vld <= '0;
            for (int i = 0; i < DL; i++) dl_addr[i] <= '0;
        end else begin
            dl_vld[0]  <= rd_en;
            dl_addr[0] <= grp_q;
            for (int i = 1; i < DL; i++) begin
                dl_vld[i]  <= dl_vld[i-1];
                dl_addr[i] <= dl_addr[i-1];
            end
        end
    end

    // Twiddle index lags the read address by the memory latency and holds otherwise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_idx <= '0;
        end else if (rd_en) begin
            w_idx <= op_q ? '0 : WW'(stage_q) * WW'(GROUPS) + WW'(grp_q);
        end
    end

    assign rd_en      = (state_q == S_ISSUE);
    assign busy       = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign done       = (state_q == S_DONE);
    assign array_mode = busy && op_q;
    assign rd_addr    = grp_q;
    assign stage      = stage_q;
    assign rd_bank    = busy && stage_q[0];
    assign wr_bank    = busy && !stage_q[0];
    assign wr_en      = dl_vld[DL-1];
    assign wr_addr    = dl_addr[DL-1];

endmodule

// File: doc/ntt_stage_controller.md
# ntt_stage_controller

Sequencer for the butterfly array. On a `start` command it runs either a full multi-stage NTT (butterfly mode) or a single pointwise-multiply pass (multiply mode). For every cycle it generates the coefficient-memory read and write strobes and addresses, the twiddle LUT index, the array mode and the ping-pong bank selects. It also tracks the read and pipeline latency, so each write lands on the row its read produced. It sits between the top-level command interface and the coefficient memory plus butterfly array.

## Interface
- `NUM_STAGES`, default 7: number of NTT stages in butterfly mode.
- `GROUPS`, default 8: rows (array-wide vectors) issued per stage.
- `BF_LATENCY`, default 4: butterfly array pipeline depth in cycles.
- `LUT_SIZE`, default 1360: twiddle LUT depth. `NUM_STAGES*GROUPS <= LUT_SIZE` is required.

- `clk`: input, 1 bit. Single clock; all logic on the rising edge.
- `reset`: input, 1 bit. Asynchronous, active-high.
- `start`: input, 1 bit. Command strobe; sampled only in IDLE.
- `op`: input, 1 bit. 0 = NTT butterfly, 1 = pointwise multiply. Latched with `start`.
- `busy`: output, 1 bit. High from the first issue cycle through the final write.
- `done`: output, 1 bit. One-cycle pulse after the final write.
- `array_mode`: output, 1 bit. Drives the array `mode`; equals the latched `op` while busy, 0 otherwise.
- `w_idx`: output, `$clog2(LUT_SIZE)+1` bits. Twiddle index, aligned with read data at the array input.
- `rd_en`: output, 1 bit. Memory read strobe.
- `rd_addr`: output, `$clog2(GROUPS)` bits. Row read address.
- `rd_bank`: output, 1 bit. Bank read this stage.
- `wr_en`: output, 1 bit. Memory write strobe.
- `wr_addr`: output, `$clog2(GROUPS)` bits. Row write address.
- `wr_bank`: output, 1 bit. Bank written this stage.
- `stage`: output, `$clog2(NUM_STAGES)+1` bits. Current issuing stage.

## Operation
- States:
  - IDLE → ISSUE on `start`.
  - ISSUE: `GROUPS` cycles, with `rd_en`=1 and `rd_addr` counting 0..`GROUPS`-1.
  - DRAIN: wait until the last write of the stage.
  - After DRAIN: go to ISSUE (next stage) or DONE.
  - DONE: one cycle, then IDLE.
- Butterfly mode runs stages 0..`NUM_STAGES`-1.
  - Within a stage, `rd_bank` = `stage[0]` and `wr_bank` = ~`stage[0]`.
  - The final result sits in bank `NUM_STAGES[0]`.
- Multiply mode runs a single pass as stage 0, with `rd_bank`=0, `wr_bank`=1 and `w_idx`=0.
- Twiddle index:
  - `w_idx` = `stage*GROUPS + g`, where g is the row read one cycle earlier.
  - It is registered one cycle behind `rd_addr` to match the 1-cycle memory read latency.
  - `w_idx` holds its value when not valid.
- Write path:
  - `wr_en` and `wr_addr` are `rd_en` and `rd_addr` delayed by `1+BF_LATENCY` cycles through a shift register.
  - `wr_bank` is constant per stage.
- The next stage never issues until the previous stage's last write has completed, which prevents read-before-write hazards.
- `start` during busy or DONE is ignored; `op` changes while busy have no effect.
- A `start` asserted in the same cycle as the DONE pulse is ignored; it must be reasserted in IDLE.
- Reset at any time, including mid-operation:
  - State returns to IDLE and all counters and the delay line clear.
  - All outputs go to 0 immediately (asynchronously).
  - No residual `wr_en` appears after reset deasserts.

## Timing
- Reset value of every output: 0.
- `start` sampled high at edge 0 → first `rd_en`/`busy` in cycle 1.
- Stage period: `GROUPS+1+BF_LATENCY` cycles. The next stage's first issue is the cycle after the previous stage's last `wr_en`.
- Butterfly total: `busy` lasts `NUM_STAGES*(GROUPS+1+BF_LATENCY)` cycles, then `done` in the following cycle with `busy`=0.
- Multiply total: `busy` lasts `GROUPS+1+BF_LATENCY` cycles, then `done`.
- `array_mode` is stable for the whole of `busy` and returns to 0 with `done`.

## Test plan
All scenarios use `NUM_STAGES`=3, `GROUPS`=4, `BF_LATENCY`=4 unless stated.
- **Butterfly run.** Stimulus: `start`, `op`=0 at edge 0. Required response:
  - Reads in cycles 1–4, 10–13 and 19–22.
  - Writes in cycles 6–9, 15–18 and 24–27.
  - `done` in cycle 28.
  - `w_idx` = 0..3, 4..7, 8..11 in cycles 2–5, 11–14 and 20–23.
- **Multiply run.** Stimulus: `op`=1. Required response:
  - Reads in cycles 1–4, writes in cycles 6–9, `done` in cycle 10.
  - `array_mode`=1 throughout cycles 1–9; `w_idx`=0.
- **Bank ping-pong.** Required response: stages 0/1/2 have `rd_bank` 0/1/0 and `wr_bank` 1/0/1; `wr_addr` sequence is 0,1,2,3 per stage.
- **Ignored start.** Stimulus: pulse `start` with `op`=1 in cycle 12 of a butterfly run. Required response: schedule unchanged, `array_mode` stays 0, single `done` in cycle 28.
- **Mid-op reset.** Stimulus: assert `reset` in cycle 16. Required response:
  - All outputs drop to 0 at once, and no `wr_en` occurs afterwards.
  - A fresh `start` after release reproduces the butterfly-run timing exactly.
- **Back-to-back commands.** Stimulus: `start` held high continuously. Required response: the second run begins 2 cycles after `done` (DONE → IDLE sample → issue), and no overlap of writes between the two runs.
